// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: funct3 encodings, CSR address
// constants and the access FSM state encoding.
package csr_access_unit_pkg;

    localparam int XLEN    = 32;
    localparam int CSR_AW  = 12;
    localparam int FIELD_W = 5;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MHARTID  = 12'hF14;

    // address[11:10] == 2'b11 marks the read-only CSR space
    localparam logic [1:0] RO_REGION = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESPOND = 2'd3
    } csr_state_e;

endpackage

// File: rtl/csr_access_unit_if.sv
// Bus bundle for the CSR access unit: core request, CSR file port and core response.
interface csr_access_unit_if;
    import csr_access_unit_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds valid and payload stable until that edge.
    logic                 request_valid;
    logic                 request_ready;
    logic [2:0]           request_funct3;
    logic [CSR_AW-1:0]    request_csr_address;
    logic [FIELD_W-1:0]   request_rs1_field;
    logic [XLEN-1:0]      request_rs1_value;

    logic [CSR_AW-1:0]    csr_address;
    logic [XLEN-1:0]      csr_read_value;
    logic [XLEN-1:0]      csr_write_value;
    logic                 csr_write_enable;

    logic                 response_valid;
    logic                 response_ready;
    logic [XLEN-1:0]      response_value;
    logic                 response_illegal;

    modport slave (
        input  request_valid, request_funct3, request_csr_address,
               request_rs1_field, request_rs1_value,
        output request_ready,
        output csr_address, csr_write_value, csr_write_enable,
        input  csr_read_value,
        output response_valid, response_value, response_illegal,
        input  response_ready
    );

    modport master (
        output request_valid, request_funct3, request_csr_address,
               request_rs1_field, request_rs1_value,
        input  request_ready,
        input  csr_address, csr_write_value, csr_write_enable,
        output csr_read_value,
        input  response_valid, response_value, response_illegal,
        output response_ready
    );

endinterface

// File: rtl/csr_rmw.sv
// Combinational read-modify-write: new CSR value, write suppression and
// illegal-access detection for one Zicsr instruction.
module csr_rmw
    import csr_access_unit_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic [1:0]         address_region,
    input  logic [FIELD_W-1:0] rs1_field,
    input  logic [XLEN-1:0]    rs1_value,
    input  logic [XLEN-1:0]    old_value,
    output logic [XLEN-1:0]    new_value,
    output logic               write_suppress,
    output logic               illegal
);

    logic [XLEN-1:0] source;

    always_comb begin
        source         = funct3[2] ? {{(XLEN-FIELD_W){1'b0}}, rs1_field} : rs1_value;
        new_value      = old_value;
        write_suppress = 1'b0;
        illegal        = 1'b0;

        case (funct3[1:0])
            2'b01:   new_value = source;
            2'b10:   new_value = old_value | source;
            2'b11:   new_value = old_value & ~source;
            default: new_value = old_value;
        endcase

        // Set/clear with x0 or zimm=0 are pure reads, so they may target read-only CSRs
        write_suppress = funct3[1] && (rs1_field == '0);
        illegal        = (funct3[1:0] == 2'b00) ||
                         (!write_suppress && (address_region == RO_REGION));
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction: latch request, read old value, optional
// single-cycle write, then hold the response until the core takes it.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                abort,
    csr_access_unit_if.slave    bus,
    output csr_state_e          debug_state
);

    csr_state_e           state;
    logic [2:0]           funct3_q;
    logic [CSR_AW-1:0]    address_q;
    logic [FIELD_W-1:0]   field_q;
    logic [XLEN-1:0]      rs1_value_q;
    logic [XLEN-1:0]      old_q;
    logic                 illegal_q;
    logic                 write_enable_q;
    logic [XLEN-1:0]      write_value_q;
    logic                 response_valid_q;
    logic [XLEN-1:0]      response_value_q;
    logic                 response_illegal_q;

    logic [XLEN-1:0]      rmw_new_value;
    logic                 rmw_suppress;
    logic                 rmw_illegal;

    csr_rmw u_rmw (
        .funct3         (funct3_q),
        .address_region (address_q[11:10]),
        .rs1_field      (field_q),
        .rs1_value      (rs1_value_q),
        .old_value      (bus.csr_read_value),
        .new_value      (rmw_new_value),
        .write_suppress (rmw_suppress),
        .illegal        (rmw_illegal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            funct3_q           <= '0;
            address_q          <= '0;
            field_q            <= '0;
            rs1_value_q        <= '0;
            old_q              <= '0;
            illegal_q          <= 1'b0;
            write_enable_q     <= 1'b0;
            write_value_q      <= '0;
            response_valid_q   <= 1'b0;
            response_value_q   <= '0;
            response_illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.request_valid) begin
                        funct3_q    <= bus.request_funct3;
                        address_q   <= bus.request_csr_address;
                        field_q     <= bus.request_rs1_field;
                        rs1_value_q <= bus.request_rs1_value;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        old_q          <= bus.csr_read_value;
                        illegal_q      <= rmw_illegal;
                        write_enable_q <= !rmw_suppress && !rmw_illegal;
                        write_value_q  <= rmw_new_value;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    write_enable_q <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        response_valid_q   <= 1'b1;
                        response_value_q   <= illegal_q ? '0 : old_q;
                        response_illegal_q <= illegal_q;
                        state              <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (bus.response_ready) begin
                        response_valid_q <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.request_ready    = (state == ST_IDLE);
    assign bus.csr_address      = address_q;
    assign bus.csr_write_value  = write_value_q;
    // An abort arriving during the write cycle must cancel the write in that same cycle
    assign bus.csr_write_enable = write_enable_q && !abort;
    assign bus.response_valid   = response_valid_q;
    assign bus.response_value   = response_value_q;
    assign bus.response_illegal = response_illegal_q;
    assign debug_state          = state;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: vector table, random accesses and
// hand-written abort, reset and backpressure sequences.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  typedef struct {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  field;
    logic [31:0] value;
    logic [31:0] old;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rsp;
    logic        exp_ill;
  } vec_t;

  localparam int NUM_VECS = 13;

  logic clock;
  logic reset_n;
  logic abort;
  csr_state_e debug_state;
  logic [31:0] csr_rdata;

  csr_access_unit_if bus();

  csr_access_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .abort       (abort),
    .bus         (bus),
    .debug_state (debug_state)
  );

  assign bus.csr_read_value = csr_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] exp_wr_q[$];
  logic [32:0] exp_rsp_q[$];
  logic [43:0] wr_e;
  logic [32:0] rsp_e;
  vec_t vecs[NUM_VECS];

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.csr_write_enable) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 32'(bus.csr_write_enable), 32'd0);
        end else begin
          wr_e = exp_wr_q.pop_front();
          check("write_address", 32'(bus.csr_address), 32'(wr_e[43:32]));
          check("write_value", bus.csr_write_value, wr_e[31:0]);
        end
      end
      if (bus.response_valid && bus.response_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_response", 32'(bus.response_valid), 32'd0);
        end else begin
          rsp_e = exp_rsp_q.pop_front();
          check("response_value", bus.response_value, rsp_e[31:0]);
          check("response_illegal", 32'(bus.response_illegal), 32'(rsp_e[32]));
        end
      end
    end
  end

  // driver tasks
  task automatic drive_request(input logic [2:0] f3, input logic [11:0] addr,
                               input logic [4:0] field, input logic [31:0] value);
    bus.request_funct3      = f3;
    bus.request_csr_address = addr;
    bus.request_rs1_field   = field;
    bus.request_rs1_value   = value;
    bus.request_valid       = 1'b1;
  endtask

  // Full access with zero-wait response_ready; entered just after a rising edge.
  task automatic do_access(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [4:0] field, input logic [31:0] value,
                           input logic [31:0] old, input logic exp_we,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rsp,
                           input logic exp_ill);
    if (exp_we) exp_wr_q.push_back({addr, exp_wdata});
    exp_rsp_q.push_back({exp_ill, exp_rsp});
    csr_rdata = old;
    drive_request(f3, addr, field, value);
    check("ready_in_idle", 32'(bus.request_ready), 32'd1);
    @(posedge clock); #1;
    bus.request_valid = 1'b0;
    @(negedge clock);
    check("read_address", 32'(bus.csr_address), 32'(addr));
    check("no_write_in_read", 32'(bus.csr_write_enable), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("write_slot", 32'(bus.csr_write_enable), 32'(exp_we));
    @(posedge clock);
    @(negedge clock);
    check("response_slot", 32'(bus.response_valid), 32'd1);
    check("no_write_in_respond", 32'(bus.csr_write_enable), 32'd0);
    @(posedge clock); #1;
    check("return_idle", 32'(bus.request_ready), 32'd1);
    check("response_dropped", 32'(bus.response_valid), 32'd0);
  endtask

  function automatic void model(input logic [2:0] f3, input logic [11:0] addr,
                                input logic [4:0] field, input logic [31:0] value,
                                input logic [31:0] old, output logic we,
                                output logic [31:0] wdata, output logic [31:0] rsp,
                                output logic ill);
    logic [31:0] src;
    logic sup;
    src = f3[2] ? {27'd0, field} : value;
    case (f3[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = old | src;
      2'b11:   wdata = old & ~src;
      default: wdata = old;
    endcase
    sup = (f3 == F3_CSRRS || f3 == F3_CSRRC || f3 == F3_CSRRSI || f3 == F3_CSRRCI) && (field == 5'd0);
    ill = (f3 == 3'b000) || (f3 == 3'b100) || (!sup && addr >= 12'hC00);
    we  = !sup && !ill;
    rsp = ill ? 32'd0 : old;
  endfunction

  initial begin
    logic [2:0]  r_f3;
    logic [11:0] r_addr;
    logic [4:0]  r_field;
    logic [31:0] r_value, r_old, r_wdata, r_rsp;
    logic        r_we, r_ill;

    vecs[0]  = '{F3_CSRRW,  CSR_MSCRATCH, 5'd1,  32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[1]  = '{F3_CSRRS,  CSR_MIE,      5'd5,  32'h00000880, 32'h00000008, 1'b1, 32'h00000888, 32'h00000008, 1'b0};
    vecs[2]  = '{F3_CSRRS,  CSR_MIE,      5'd0,  32'h00000880, 32'h00000008, 1'b0, 32'h0,        32'h00000008, 1'b0};
    vecs[3]  = '{F3_CSRRCI, CSR_MSTATUS,  5'h08, 32'hFFFFFFFF, 32'h00001888, 1'b1, 32'h00001880, 32'h00001888, 1'b0};
    vecs[4]  = '{F3_CSRRW,  CSR_MHARTID,  5'd1,  32'h00000055, 32'h0000ABCD, 1'b0, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{F3_CSRRS,  CSR_MHARTID,  5'd0,  32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[6]  = '{F3_CSRRS,  12'hF11,      5'd0,  32'hFFFFFFFF, 32'h00000055, 1'b0, 32'h0,        32'h00000055, 1'b0};
    vecs[7]  = '{3'b000,    CSR_MSCRATCH, 5'd3,  32'h00000001, 32'h00001111, 1'b0, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{3'b100,    CSR_MSCRATCH, 5'd3,  32'h00000001, 32'h00002222, 1'b0, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{F3_CSRRWI, 12'h341,      5'h1F, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h0000001F, 32'h0,        1'b0};
    vecs[10] = '{F3_CSRRSI, 12'h342,      5'd3,  32'h0,        32'h00000010, 1'b1, 32'h00000013, 32'h00000010, 1'b0};
    vecs[11] = '{F3_CSRRC,  12'h343,      5'd2,  32'h000000F0, 32'h000000FF, 1'b1, 32'h0000000F, 32'h000000FF, 1'b0};
    vecs[12] = '{F3_CSRRW,  12'hC00,      5'd0,  32'h00000007, 32'h00000077, 1'b0, 32'h0,        32'h0,        1'b1};

    reset_n = 1'b0;
    abort = 1'b0;
    csr_rdata = 32'd0;
    bus.request_valid = 1'b0;
    bus.request_funct3 = 3'd0;
    bus.request_csr_address = 12'd0;
    bus.request_rs1_field = 5'd0;
    bus.request_rs1_value = 32'd0;
    bus.response_ready = 1'b1;

    #2;
    check("reset_write_enable", 32'(bus.csr_write_enable), 32'd0);
    check("reset_response_valid", 32'(bus.response_valid), 32'd0);
    check("reset_csr_address", 32'(bus.csr_address), 32'd0);
    check("reset_write_value", bus.csr_write_value, 32'd0);
    check("reset_response_value", bus.response_value, 32'd0);
    check("reset_response_illegal", 32'(bus.response_illegal), 32'd0);
    check("reset_state", 32'(debug_state), 32'(ST_IDLE));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", 32'(bus.request_ready), 32'd1);

    for (int i = 0; i < NUM_VECS; i++) begin
      do_access(vecs[i].funct3, vecs[i].addr, vecs[i].field, vecs[i].value, vecs[i].old,
                vecs[i].exp_we, vecs[i].exp_wdata, vecs[i].exp_rsp, vecs[i].exp_ill);
    end

    for (int i = 0; i < 24; i++) begin
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 12'($urandom_range(0, 4095));
      r_field = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_value = $urandom;
      r_old   = $urandom;
      model(r_f3, r_addr, r_field, r_value, r_old, r_we, r_wdata, r_rsp, r_ill);
      do_access(r_f3, r_addr, r_field, r_value, r_old, r_we, r_wdata, r_rsp, r_ill);
    end

    // abort while reading
    csr_rdata = 32'h11110000;
    drive_request(F3_CSRRW, CSR_MSCRATCH, 5'd1, 32'h0000AAAA);
    @(posedge clock); #1;
    bus.request_valid = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    check("abort_read_no_write", 32'(bus.csr_write_enable), 32'd0);
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_read_ready", 32'(bus.request_ready), 32'd1);
    check("abort_read_no_response", 32'(bus.response_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("abort_read_still_idle", 32'(debug_state), 32'(ST_IDLE));

    // abort during the write cycle
    drive_request(F3_CSRRW, CSR_MSCRATCH, 5'd1, 32'h0000BBBB);
    @(posedge clock); #1;
    bus.request_valid = 1'b0;
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    check("abort_write_gated", 32'(bus.csr_write_enable), 32'd0);
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_write_ready", 32'(bus.request_ready), 32'd1);
    check("abort_write_no_response", 32'(bus.response_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;

    // response backpressure; abort and a new request must be ignored meanwhile
    bus.response_ready = 1'b0;
    csr_rdata = 32'hCAFE0001;
    exp_wr_q.push_back({CSR_MSCRATCH, 32'h00001234});
    exp_rsp_q.push_back({1'b0, 32'hCAFE0001});
    drive_request(F3_CSRRW, CSR_MSCRATCH, 5'd1, 32'h00001234);
    @(posedge clock); #1;
    drive_request(F3_CSRRW, 12'h341, 5'd2, 32'h0000FFFF);
    repeat (2) @(posedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(bus.response_valid), 32'd1);
      check("stall_value", bus.response_value, 32'hCAFE0001);
      check("stall_illegal", 32'(bus.response_illegal), 32'd0);
      check("stall_not_ready", 32'(bus.request_ready), 32'd0);
      check("stall_no_write", 32'(bus.csr_write_enable), 32'd0);
      @(posedge clock); #1;
      abort = (i == 1);
    end
    abort = 1'b0;
    bus.response_ready = 1'b1;
    bus.request_valid = 1'b0;
    @(negedge clock);
    check("stall_release_valid", 32'(bus.response_valid), 32'd1);
    @(posedge clock); #1;
    check("stall_release_idle", 32'(bus.request_ready), 32'd1);
    repeat (3) @(posedge clock);
    #1;

    // reset asserted in the write cycle
    csr_rdata = 32'd0;
    exp_wr_q.push_back({CSR_MSCRATCH, 32'h0BADF00D});
    drive_request(F3_CSRRW, CSR_MSCRATCH, 5'd1, 32'h0BADF00D);
    @(posedge clock); #1;
    bus.request_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("reset_write_active", 32'(bus.csr_write_enable), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_write_dropped", 32'(bus.csr_write_enable), 32'd0);
    check("reset_mid_response_valid", 32'(bus.response_valid), 32'd0);
    check("reset_mid_csr_address", 32'(bus.csr_address), 32'd0);
    check("reset_mid_write_value", bus.csr_write_value, 32'd0);
    check("reset_mid_state", 32'(debug_state), 32'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("reset_mid_ready", 32'(bus.request_ready), 32'd1);
    check("reset_mid_no_response", 32'(bus.response_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;

    // one more normal access to show recovery
    do_access(vecs[0].funct3, vecs[0].addr, vecs[0].field, vecs[0].value, vecs[0].old,
              vecs[0].exp_we, vecs[0].exp_wdata, vecs[0].exp_rsp, vecs[0].exp_ill);

    repeat (3) @(posedge clock);
    check("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("response_queue_drained", 32'(exp_rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have ports: clock  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: request_valid  input  1 / request_ready  output  1  core-side request handshake.
REQ-004 SHALL have ports: request_funct3  input  3 / request_csr_address  input  12 / request_rs1_field  input  5 (register index or zimm) / request_rs1_value  input  32.
REQ-005 SHALL have ports: csr_address  output  12 / csr_read_value  input  32 (combinational read) / csr_write_value  output  32 / csr_write_enable  output  1  CSR file side.
REQ-006 SHALL have ports: abort  input  1  trap/flush from core, cancels in-flight access.
REQ-007 SHALL have ports: response_valid  output  1 / response_ready  input  1 / response_value  output  32 (old CSR value for rd) / response_illegal  output  1.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WRITE, RESPOND; request_ready=1 only in IDLE.
REQ-009 SHALL, in IDLE with request_valid=1, latch funct3, address, rs1_field, rs1_value and go to READ.
REQ-010 SHALL, in READ, drive csr_address from the latched address and capture csr_read_value as old value, then go to WRITE.
REQ-011 SHALL compute source = rs1_value when funct3[2]=0, else {27'b0, rs1_field}.
REQ-012 SHALL compute new value: funct3[1:0]=01 -> source; 10 -> old|source; 11 -> old&~source.
REQ-013 SHALL suppress write when funct3[1:0] is 10 or 11 and rs1_field=0.
REQ-014 SHALL flag illegal when funct3 is 000 or 100, or when a non-suppressed write targets address[11:10]=11 (read-only space).
REQ-015 SHALL, in WRITE, assert csr_write_enable for exactly one cycle with csr_write_value=new value and csr_address held, unless suppressed or illegal; then go to RESPOND.
REQ-016 SHALL, in RESPOND, hold response_valid=1, response_value=old value (0 if illegal), response_illegal stable until response_ready=1, then return to IDLE.
REQ-017 SHALL give fixed latency: request accepted at edge N, write at edge N+2, response_valid high from after edge N+2 (zero-wait response_ready -> IDLE after edge N+3).
REQ-018 SHALL, on abort=1 in READ or WRITE, return to IDLE next edge with csr_write_enable=0 that cycle and no response.
REQ-019 SHALL ignore abort in IDLE and RESPOND.
REQ-020 SHALL keep csr_write_enable=0 in every state other than WRITE.

Reset
REQ-021 SHALL, on reset_n=0 at any time including mid-access, enter IDLE immediately with request_ready=1 after deassertion, response_valid=0, csr_write_enable=0, csr_address=0, csr_write_value=0, response_value=0, response_illegal=0.
REQ-022 SHALL never emit a partial write: a reset asserted during WRITE drops csr_write_enable asynchronously.

Structure
REQ-023 SHALL take CSR address constants, funct3 encodings (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111) and FSM state encodings from shared header csr_defines.vh, also used by csr.
REQ-024 SHALL place the combinational new-value/suppress/illegal computation in one sub-module csr_rmw.

Verification
REQ-025 SHALL cover: CSRRW addr 0x340, rs1_value 0xDEADBEEF, CSR reads 0x12345678 -> one write of 0xDEADBEEF, response_value 0x12345678, illegal=0.
REQ-026 SHALL cover: CSRRS addr 0x304, rs1_field 5, rs1_value 0x00000880, old 0x00000008 -> write 0x00000888; same with rs1_field 0 -> no write, response 0x00000008.
REQ-027 SHALL cover: CSRRCI addr 0x300, zimm 0x08, old 0x00001888 -> write 0x00001880.
REQ-028 SHALL cover: CSRRW addr 0xF14 -> no write, response_illegal=1, response_value 0; CSRRS addr 0xF14 rs1_field 0 -> legal, response 0.
REQ-029 SHALL cover: abort pulsed in READ -> no csr_write_enable, no response_valid, request_ready=1 next cycle; reset_n dropped in WRITE -> csr_write_enable falls immediately.
REQ-030 SHALL cover: response_ready held 0 for 5 cycles -> response_valid/value stable, request_valid ignored until handshake completes.
